// File: rtl/dmem_pkg.sv
// Shared types and address helpers for the multi-cycle data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int LATENCY_MIN = 1;

    function automatic logic [31:0] word_idx(input logic [31:0] addr);
        return addr >> 2;
    endfunction

    // Compared at 34 bits so 4*depth cannot overflow; there is no wrap-around.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        logic [33:0] limit;
        limit = {2'b00, depth} << 2;
        return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write, registered read, contents never reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Stall-generating MEM-stage data port: one outstanding access, fixed latency,
// one-cycle ack, misaligned/out-of-range accesses flagged instead of performed.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4,
    parameter int DATA_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic              ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic              err_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic              fire;
    logic              acc_we;
    logic              acc_err;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_wdata;
    logic              arr_we;
    logic              arr_re;
    logic [DATA_W-1:0] arr_rdata;

    // fire marks the cycle whose closing edge performs the access (last BUSY, or IDLE when LATENCY=1).
    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        accept     = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                stall_o = req_i;
                if (req_i) begin
                    accept = 1'b1;
                    if (LATENCY <= LATENCY_MIN) begin
                        fire       = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    fire       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt <= CNT_LOAD;
            end else if (state == BUSY) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_q    <= we_i;
            err_q   <= addr_err(addr_i, DEPTH_WORDS);
            idx_q   <= IDX_W'(word_idx(addr_i));
            wdata_q <= wdata_i;
        end
    end

    // The single-cycle configuration accesses straight from the request inputs.
    assign acc_we    = accept ? we_i : we_q;
    assign acc_err   = accept ? addr_err(addr_i, DEPTH_WORDS) : err_q;
    assign acc_idx   = accept ? IDX_W'(word_idx(addr_i)) : idx_q;
    assign acc_wdata = accept ? wdata_i : wdata_q;

    assign arr_we = fire && acc_we && !acc_err && !rst_i;
    assign arr_re = fire && !acc_we && !acc_err && !rst_i;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk_i),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    assign ack_o   = (state == DONE);
    assign err_o   = ack_o && err_q;
    assign rdata_o = (ack_o && !we_q && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized checks of data_mem_responder at LATENCY=4 and LATENCY=1
// against a word-keyed memory model and the request/ack timing rules.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req4 = 1'b0, we4 = 1'b0;
    logic [31:0] addr4 = '0, wdata4 = '0;
    wire         stall4, ack4, err4;
    wire  [31:0] rdata4;

    logic        req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr1 = '0, wdata1 = '0;
    wire         stall1, ack1, err1;
    wire  [31:0] rdata1;

    int checks = 0;
    int errors = 0;

    logic [31:0] model4 [int];
    logic [31:0] model1 [int];

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req4), .we_i(we4), .addr_i(addr4), .wdata_i(wdata4),
        .stall_o(stall4), .ack_o(ack4), .rdata_o(rdata4), .err_o(err4)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .DATA_W(32)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1), .wdata_i(wdata1),
        .stall_o(stall1), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1)
    );

    // The requester must hold req_i until ack; stall without req outside reset means it let go mid-access.
    always @(posedge clk) begin
        if (rst === 1'b0) begin
            assert (!(stall4 === 1'b1 && req4 === 1'b0))
                else $error("[TB] protocol violation: req_i dropped while LATENCY=4 instance busy");
            assert (!(stall1 === 1'b1 && req1 === 1'b0))
                else $error("[TB] protocol violation: req_i dropped while LATENCY=1 instance busy");
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
            else begin
                errors++;
                $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
            end
    endtask

    task automatic applyStimulus(input int inst, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (inst == 1) begin
            req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req4 = req; we4 = we; addr4 = addr; wdata4 = wdata;
        end
    endtask

    task automatic sampleOutputs(input int inst, output logic st, output logic ak,
                                 output logic er, output logic [31:0] rd);
        if (inst == 1) begin
            st = stall1; ak = ack1; er = err1; rd = rdata1;
        end else begin
            st = stall4; ak = ack4; er = err4; rd = rdata4;
        end
    endtask

    // Called just after a rising edge; returns just after the rising edge that ends the ack cycle.
    task automatic runAccess(input int inst, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input string tag);
        int          lat;
        int          key;
        bit          exp_err;
        bit          rd_known;
        logic [31:0] exp_rd;
        logic        st, ak, er;
        logic [31:0] rd;

        lat      = (inst == 1) ? 1 : 4;
        key      = int'(addr / 4);
        exp_err  = (addr % 4 != 0) || (addr >= 32'd4096);
        rd_known = 1'b1;
        exp_rd   = 32'h0;
        if (!we && !exp_err) begin
            if (inst == 1) begin
                rd_known = model1.exists(key);
                if (rd_known) exp_rd = model1[key];
            end else begin
                rd_known = model4.exists(key);
                if (rd_known) exp_rd = model4[key];
            end
        end

        applyStimulus(inst, 1'b1, we, addr, wdata);
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            sampleOutputs(inst, st, ak, er, rd);
            checkOutput({tag, "_stall"}, {31'b0, st}, 32'd1);
            checkOutput({tag, "_ack_early"}, {31'b0, ak}, 32'd0);
            checkOutput({tag, "_rdata_idle"}, rd, 32'h0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        sampleOutputs(inst, st, ak, er, rd);
        checkOutput({tag, "_ack"}, {31'b0, ak}, 32'd1);
        checkOutput({tag, "_stall_done"}, {31'b0, st}, 32'd0);
        checkOutput({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
        if (rd_known) checkOutput({tag, "_rdata"}, rd, exp_rd);

        if (we && !exp_err) begin
            if (inst == 1) model1[key] = wdata;
            else           model4[key] = wdata;
        end
        @(posedge clk);
        #1;
        applyStimulus(inst, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic        st, ak, er;
        logic [31:0] rd;
        logic [31:0] ra;
        int          sel;

        // Reset and the cycle after it
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int inst = 1; inst <= 4; inst += 3) begin
            sampleOutputs(inst, st, ak, er, rd);
            checkOutput("reset_stall", {31'b0, st}, 32'd0);
            checkOutput("reset_ack", {31'b0, ak}, 32'd0);
            checkOutput("reset_err", {31'b0, er}, 32'd0);
            checkOutput("reset_rdata", rd, 32'h0);
        end
        @(posedge clk);
        #1;

        // Store then back-to-back load of the same word
        runAccess(4, 1'b1, 32'h10, 32'hDEADBEEF, "t1_store");
        runAccess(4, 1'b0, 32'h10, 32'h0, "t2_load");

        // Misaligned load leaves memory untouched
        runAccess(4, 1'b0, 32'h13, 32'h0, "t3_misaligned");
        runAccess(4, 1'b0, 32'h10, 32'h0, "t3_recheck");

        // Out-of-range store must not wrap onto word 0
        runAccess(4, 1'b1, 32'h0, 32'h11111111, "t4_prep");
        runAccess(4, 1'b1, 32'h1000, 32'h1234, "t4_oor");
        runAccess(4, 1'b0, 32'h0, 32'h0, "t4_word0");
        runAccess(4, 1'b0, 32'hFFFFFFFC, 32'h0, "t4_top_addr");

        // Reset in cycle 2 of a store aborts it
        runAccess(4, 1'b1, 32'h20, 32'h0BADF00D, "t5_prep");
        applyStimulus(4, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
        repeat (2) begin
            @(negedge clk);
            checkOutput("t5_stall_before_reset", {31'b0, stall4}, 32'd1);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        applyStimulus(4, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("t5_after_reset_stall", {31'b0, stall4}, 32'd0);
            checkOutput("t5_after_reset_ack", {31'b0, ack4}, 32'd0);
            checkOutput("t5_after_reset_err", {31'b0, err4}, 32'd0);
            checkOutput("t5_after_reset_rdata", rdata4, 32'h0);
            @(posedge clk);
            #1;
        end
        runAccess(4, 1'b0, 32'h20, 32'h0, "t5_load_old");

        // LATENCY=1 with req_i held across store and load
        applyStimulus(1, 1'b1, 1'b1, 32'h8, 32'h55);
        @(negedge clk);
        checkOutput("t6_c0_stall", {31'b0, stall1}, 32'd1);
        checkOutput("t6_c0_ack", {31'b0, ack1}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t6_c1_ack", {31'b0, ack1}, 32'd1);
        checkOutput("t6_c1_stall", {31'b0, stall1}, 32'd0);
        checkOutput("t6_c1_err", {31'b0, err1}, 32'd0);
        checkOutput("t6_c1_rdata", rdata1, 32'h0);
        @(posedge clk);
        #1;
        model1[2] = 32'h55;
        applyStimulus(1, 1'b1, 1'b0, 32'h8, 32'h0);
        @(negedge clk);
        checkOutput("t6_c2_ack", {31'b0, ack1}, 32'd0);
        checkOutput("t6_c2_stall", {31'b0, stall1}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t6_c3_ack", {31'b0, ack1}, 32'd1);
        checkOutput("t6_c3_rdata", rdata1, 32'h55);
        checkOutput("t6_c3_err", {31'b0, err1}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t6_c4_ack", {31'b0, ack1}, 32'd0);
        checkOutput("t6_c4_stall", {31'b0, stall1}, 32'd0);
        @(posedge clk);
        #1;

        // Randomized mix on both instances, mostly to a small word window so loads hit stored data
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      ra = ($urandom_range(0, 1023) * 4) + $urandom_range(1, 3);
            else if (sel == 1) ra = 32'h1000 + $urandom_range(0, 4095) * 4;
            else               ra = $urandom_range(0, 15) * 4;
            runAccess((n % 4 == 3) ? 1 : 4, 1'($urandom_range(0, 1)), ra, $urandom, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
